// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one external memory port between the I-cache refill
//               path and the D-cache refill/write-back path. Round-robin
//               arbitration in IDLE, one burst command per grant, beat
//               counting, and routing of read beats back to the winner.
// Ports       : clk, rst            - clock, async active-high reset
//               i_req/i_addr        - I-cache burst read request
//               i_rdata/i_rvalid    - read beats to I-cache
//               i_done              - I burst complete pulse
//               d_req/d_we/d_addr   - D-cache burst request (read or write)
//               d_wdata/d_wnext     - write-back beat and consume strobe
//               d_rdata/d_rvalid    - read beats to D-cache
//               d_done              - D burst complete pulse
//               mem_cmd_*           - burst command handshake
//               mem_wdata/wvalid/wready - write beat handshake
//               mem_rdata/rvalid    - read beats (no backpressure)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // I-cache side
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    output logic                  i_done,
    // D-cache side
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wnext,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic                  d_done,
    // Memory side
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_we,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int                CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    state_t                  state_q,  state_d;
    grant_t                  grant_q,  grant_d;
    logic                    last_d_q, last_d_d;   // 1: D won the previous arbitration
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic                    we_q,     we_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;

    // D wins when it is the only requester, or when both request and I
    // was served last.
    logic w_pick_d;
    assign w_pick_d = d_req && (!i_req || !last_d_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= GNT_NONE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d_d      = last_d_q;
        addr_d        = addr_q;
        we_d          = we_q;
        cnt_d         = cnt_q;

        i_rdata       = '0;
        i_rvalid      = 1'b0;
        i_done        = 1'b0;
        d_wnext       = 1'b0;
        d_rdata       = '0;
        d_rvalid      = 1'b0;
        d_done        = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_we    = 1'b0;
        mem_cmd_addr  = '0;
        mem_wdata     = '0;
        mem_wvalid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // Address and direction are captured here so the
                    // requester may change them freely once granted.
                    grant_d  = w_pick_d ? GNT_D : GNT_I;
                    last_d_d = w_pick_d;
                    addr_d   = w_pick_d ? d_addr : i_addr;
                    we_d     = w_pick_d && d_we;
                    state_d  = ST_CMD;
                end
            end

            ST_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_addr  = addr_q;
                mem_cmd_we    = we_q;
                if (mem_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = we_q ? ST_WRITE : ST_READ;
                end
            end

            ST_WRITE: begin
                mem_wvalid = 1'b1;
                mem_wdata  = d_wdata;
                if (mem_wready) begin
                    d_wnext = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_READ: begin
                if (mem_rvalid) begin
                    if (grant_q == GNT_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rdata  = mem_rdata;
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                i_done  = (grant_q == GNT_I);
                d_done  = (grant_q == GNT_D);
                grant_d = GNT_NONE;
                state_d = ST_IDLE;
            end

            default: begin
                grant_d = GNT_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
